// File: rtl/rd53_lbnl_fe_pkg.sv
// Shared types and default widths for the LBNL differential front-end pixel controller.
package rd53_lbnl_fe_pkg;

    localparam int TOT_W_DEF  = 4;
    localparam int TS_W_DEF   = 8;
    localparam int LOST_W_DEF = 8;
    localparam int CFG_W      = 10;

    typedef struct packed {
        logic       s1;
        logic       s0;
        logic [3:0] dth2;
        logic [3:0] dth1;
    } fe_cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } fe_state_e;

    function automatic fe_cfg_t cfg_unpack(input logic [CFG_W-1:0] raw);
        return fe_cfg_t'(raw);
    endfunction

endpackage

// File: rtl/rd53_lbnl_fe_ctrl_sync2.sv
// Two-flop level synchronizer for asynchronous inputs, with configurable reset value.
module rd53_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // two-stage capture of the asynchronous level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/rd53_lbnl_fe_ctrl.sv
// Per-pixel LBNL AFE controller: config pins, discriminator ToT measurement and hit handshake.
module rd53_lbnl_fe_ctrl
    import rd53_lbnl_fe_pkg::*;
#(
    parameter int TOT_W  = TOT_W_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int LOST_W = LOST_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [CFG_W-1:0]  cfg_data,
    input  logic              en,
    input  logic [TS_W-1:0]   ts,
    output logic              S0,
    output logic              S1,
    output logic [3:0]        DTH1,
    output logic [3:0]        DTH2,
    input  logic              outdis,
    output logic              hit_valid,
    input  logic              hit_ready,
    output logic [TS_W-1:0]   hit_ts,
    output logic [TOT_W-1:0]  hit_tot,
    output logic [LOST_W-1:0] lost_cnt
);

    fe_cfg_t          r_cfg;
    fe_state_e        r_state;
    logic             r_disc_d;
    logic             r_hit_valid;
    logic [TS_W-1:0]  r_hit_ts;
    logic [TOT_W-1:0] r_hit_tot;
    logic [LOST_W-1:0] r_lost_cnt;

    logic w_disc_s;
    logic w_le;
    logic w_te;
    logic w_tot_max;
    logic w_lost_max;

    rd53_sync2 #(.RST_VAL(1'b0)) u_disc_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (~outdis),
        .q     (w_disc_s)
    );

    assign w_le       = w_disc_s & ~r_disc_d;
    assign w_te       = ~w_disc_s & r_disc_d;
    assign w_tot_max  = (r_hit_tot == {TOT_W{1'b1}});
    assign w_lost_max = (r_lost_cnt == {LOST_W{1'b1}});

    // configuration register, independent of the hit path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= cfg_unpack({CFG_W{1'b0}});
        end else if (cfg_wr) begin
            r_cfg <= cfg_unpack(cfg_data);
        end else begin
            r_cfg <= r_cfg;
        end
    end

    // history flop for edge detection on the synchronized discriminator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disc_d <= 1'b0;
        end else begin
            r_disc_d <= w_disc_s;
        end
    end

    // hit measurement FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hit_valid <= 1'b0;
            r_hit_ts    <= {TS_W{1'b0}};
            r_hit_tot   <= {TOT_W{1'b0}};
            r_lost_cnt  <= {LOST_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_le && en) begin
                        r_hit_ts  <= ts;
                        r_hit_tot <= TOT_W'(1);
                        r_state   <= COUNT;
                    end
                end
                COUNT: begin
                    // losing enable discards the partial measurement silently
                    if (!en) begin
                        r_state <= IDLE;
                    end else if (w_te) begin
                        r_hit_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (w_disc_s && !w_tot_max) begin
                        r_hit_tot <= r_hit_tot + TOT_W'(1);
                    end
                end
                HOLD: begin
                    if (w_le && en && !w_lost_max) begin
                        r_lost_cnt <= r_lost_cnt + LOST_W'(1);
                    end
                    if (hit_ready) begin
                        r_hit_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_hit_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign S0        = r_cfg.s0;
    assign S1        = r_cfg.s1;
    assign DTH1      = r_cfg.dth1;
    assign DTH2      = r_cfg.dth2;
    assign hit_valid = r_hit_valid;
    assign hit_ts    = r_hit_ts;
    assign hit_tot   = r_hit_tot;
    assign lost_cnt  = r_lost_cnt;

endmodule

// File: tb/tb_rd53_lbnl_fe_ctrl.sv
// Self-checking bench for rd53_lbnl_fe_ctrl: pulse-level expectations derived from the timing rules.
module tb_rd53_lbnl_fe_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cfg_wr;
    logic [9:0] cfg_data;
    logic       en;
    logic [7:0] ts;
    logic       S0, S1;
    logic [3:0] DTH1, DTH2;
    logic       outdis;
    logic       hit_valid;
    logic       hit_ready;
    logic [7:0] hit_ts;
    logic [3:0] hit_tot;
    logic [7:0] lost_cnt;

    int checks = 0;
    int errors = 0;
    int exp_lost = 0;

    rd53_lbnl_fe_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_wr    (cfg_wr),
        .cfg_data  (cfg_data),
        .en        (en),
        .ts        (ts),
        .S0        (S0),
        .S1        (S1),
        .DTH1      (DTH1),
        .DTH2      (DTH2),
        .outdis    (outdis),
        .hit_valid (hit_valid),
        .hit_ready (hit_ready),
        .hit_ts    (hit_ts),
        .hit_tot   (hit_tot),
        .lost_cnt  (lost_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // one clock edge; the BCID counter advances after every edge
    task automatic step();
        @(posedge clk);
        #1;
        ts = ts + 8'd1;
    endtask

    // outdis low for len edges; returns the BCID sampled two edges after the fall
    task automatic launch(input int len, output logic [7:0] ts_le);
        outdis = 1'b0;
        ts_le  = ts + 8'd2;
        for (int i = 0; i < len; i++) step();
        outdis = 1'b1;
    endtask

    function automatic logic [3:0] tot_of(input int len);
        return (len > 15) ? 4'd15 : 4'(len);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; cfg_wr = 1'b0; cfg_data = 10'h3FF; en = 1'b1;
        ts = 8'd0; outdis = 1'b1; hit_ready = 1'b0;
        step(); step();
        checks++;
        if ({S1, S0, DTH2, DTH1} !== 10'd0) begin
            errors++; $display("FAIL reset_cfg: got %h expected 000", {S1, S0, DTH2, DTH1});
        end
        checks++;
        if ({hit_valid, hit_ts, hit_tot, lost_cnt} !== 21'd0) begin
            errors++; $display("FAIL reset_hit: got v=%b ts=%h tot=%h lost=%h expected all 0",
                               hit_valid, hit_ts, hit_tot, lost_cnt);
        end
        rst_n = 1'b1;
        step(); step();
        checks++;
        if (hit_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release_valid: got %b expected 0", hit_valid);
        end
    endtask

    task automatic test_config();
        logic [9:0] exp_cfg;
        logic [7:0] exp_ts;
        en = 1'b1; hit_ready = 1'b1;
        exp_cfg = 10'b11_1010_0101;
        exp_ts  = ts + 8'd2;
        outdis = 1'b0; cfg_wr = 1'b1; cfg_data = exp_cfg;
        step();
        cfg_wr = 1'b0; cfg_data = 10'h000;
        checks++;
        if ({S1, S0, DTH2, DTH1} !== exp_cfg) begin
            errors++; $display("FAIL cfg_write: got %b expected %b", {S1, S0, DTH2, DTH1}, exp_cfg);
        end
        for (int i = 0; i < 5; i++) step();
        outdis = 1'b1;
        step(); step(); step();
        checks++;
        if (hit_valid !== 1'b1 || hit_ts !== exp_ts || hit_tot !== 4'd6) begin
            errors++; $display("FAIL cfg_concurrent_hit: got v=%b ts=%h tot=%0d expected v=1 ts=%h tot=6",
                               hit_valid, hit_ts, hit_tot, exp_ts);
        end
        step();
        for (int i = 0; i < 6; i++) begin
            exp_cfg = 10'($urandom);
            cfg_wr = 1'b1; cfg_data = exp_cfg;
            step();
            cfg_wr = 1'b0; cfg_data = ~exp_cfg;
            checks++;
            if (S1 !== exp_cfg[9] || S0 !== exp_cfg[8] || DTH2 !== exp_cfg[7:4] || DTH1 !== exp_cfg[3:0]) begin
                errors++; $display("FAIL cfg_random: got %b expected %b", {S1, S0, DTH2, DTH1}, exp_cfg);
            end
            step();
            checks++;
            if ({S1, S0, DTH2, DTH1} !== exp_cfg) begin
                errors++; $display("FAIL cfg_hold: got %b expected %b", {S1, S0, DTH2, DTH1}, exp_cfg);
            end
        end
    endtask

    task automatic test_basic_hit();
        logic [7:0] le_ts;
        en = 1'b1; hit_ready = 1'b1;
        ts = 8'h3A;
        launch(5, le_ts);
        step(); step();
        checks++;
        if (hit_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid: got %b expected 0", hit_valid);
        end
        step();
        checks++;
        if (hit_valid !== 1'b1 || hit_ts !== 8'h3C || hit_tot !== 4'd5) begin
            errors++; $display("FAIL basic_hit: got v=%b ts=%h tot=%0d expected v=1 ts=3c tot=5",
                               hit_valid, hit_ts, hit_tot);
        end
        step();
        checks++;
        if (hit_valid !== 1'b0) begin
            errors++; $display("FAIL basic_accept: got %b expected 0", hit_valid);
        end
    endtask

    task automatic test_random_pulses();
        logic [7:0] le_ts;
        int len, stall, gap;
        en = 1'b1;
        for (int n = 0; n < 12; n++) begin
            len   = $urandom_range(1, 30);
            stall = $urandom_range(0, 5);
            gap   = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) step();
            ts = 8'($urandom);
            hit_ready = (stall == 0);
            launch(len, le_ts);
            step(); step();
            checks++;
            if (hit_valid !== 1'b0) begin
                errors++; $display("FAIL rnd_early_valid: len=%0d got %b expected 0", len, hit_valid);
            end
            step();
            checks++;
            if (hit_valid !== 1'b1 || hit_ts !== le_ts || hit_tot !== tot_of(len)) begin
                errors++; $display("FAIL rnd_hit: len=%0d got v=%b ts=%h tot=%0d expected v=1 ts=%h tot=%0d",
                                   len, hit_valid, hit_ts, hit_tot, le_ts, tot_of(len));
            end
            for (int s = 0; s < stall; s++) begin
                step();
                checks++;
                if (hit_valid !== 1'b1 || hit_ts !== le_ts || hit_tot !== tot_of(len)) begin
                    errors++; $display("FAIL rnd_stall_stable: got v=%b ts=%h tot=%0d expected v=1 ts=%h tot=%0d",
                                       hit_valid, hit_ts, hit_tot, le_ts, tot_of(len));
                end
            end
            hit_ready = 1'b1;
            step();
            checks++;
            if (hit_valid !== 1'b0 || lost_cnt !== 8'(exp_lost)) begin
                errors++; $display("FAIL rnd_accept: got v=%b lost=%0d expected v=0 lost=%0d",
                                   hit_valid, lost_cnt, exp_lost);
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] le_ts;
        en = 1'b1; hit_ready = 1'b1;
        outdis = 1'b0;
        step(); step(); step(); step();
        en = 1'b0;
        step();
        en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        outdis = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (hit_valid !== 1'b0) begin
                errors++; $display("FAIL en_abort_no_hit: cycle %0d got %b expected 0", i, hit_valid);
            end
        end
        checks++;
        if (lost_cnt !== 8'(exp_lost)) begin
            errors++; $display("FAIL en_abort_lost: got %0d expected %0d", lost_cnt, exp_lost);
        end
        en = 1'b0;
        launch(4, le_ts);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (hit_valid !== 1'b0) begin
                errors++; $display("FAIL en_low_no_hit: cycle %0d got %b expected 0", i, hit_valid);
            end
        end
        en = 1'b1; hit_ready = 1'b0;
        launch(3, le_ts);
        step(); step(); step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (hit_valid !== 1'b1 || hit_ts !== le_ts || hit_tot !== 4'd3) begin
                errors++; $display("FAIL en_drop_hold: got v=%b ts=%h tot=%0d expected v=1 ts=%h tot=3",
                                   hit_valid, hit_ts, hit_tot, le_ts);
            end
        end
        hit_ready = 1'b1;
        step();
        checks++;
        if (hit_valid !== 1'b0) begin
            errors++; $display("FAIL en_drop_accept: got %b expected 0", hit_valid);
        end
        en = 1'b1;
        step();
    endtask

    task automatic test_stall_and_lost();
        logic [7:0] le_ts;
        logic [7:0] dummy_ts;
        en = 1'b1; hit_ready = 1'b0;
        ts = 8'($urandom);
        launch(40, le_ts);
        step(); step(); step();
        checks++;
        if (hit_valid !== 1'b1 || hit_ts !== le_ts || hit_tot !== 4'd15) begin
            errors++; $display("FAIL sat_hit: got v=%b ts=%h tot=%0d expected v=1 ts=%h tot=15",
                               hit_valid, hit_ts, hit_tot, le_ts);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (hit_valid !== 1'b1 || hit_ts !== le_ts || hit_tot !== 4'd15) begin
                errors++; $display("FAIL stall_stable: got v=%b ts=%h tot=%0d expected v=1 ts=%h tot=15",
                                   hit_valid, hit_ts, hit_tot, le_ts);
            end
        end
        launch(4, dummy_ts);
        step(); step();
        exp_lost = exp_lost + 1;
        checks++;
        if (lost_cnt !== 8'(exp_lost) || hit_ts !== le_ts || hit_tot !== 4'd15 || hit_valid !== 1'b1) begin
            errors++; $display("FAIL lost_one: got lost=%0d v=%b ts=%h tot=%0d expected lost=%0d v=1 ts=%h tot=15",
                               lost_cnt, hit_valid, hit_ts, hit_tot, exp_lost, le_ts);
        end
        for (int i = 0; i < 300; i++) begin
            outdis = 1'b0;
            step();
            outdis = 1'b1;
            step(); step();
            exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
            if (i % 50 == 49) begin
                checks++;
                if (lost_cnt !== 8'(exp_lost)) begin
                    errors++; $display("FAIL lost_progress: pulse %0d got %0d expected %0d", i, lost_cnt, exp_lost);
                end
            end
        end
        step(); step();
        checks++;
        if (lost_cnt !== 8'd255 || hit_valid !== 1'b1 || hit_ts !== le_ts || hit_tot !== 4'd15) begin
            errors++; $display("FAIL lost_saturate: got lost=%0d v=%b ts=%h tot=%0d expected lost=255 v=1 ts=%h tot=15",
                               lost_cnt, hit_valid, hit_ts, hit_tot, le_ts);
        end
        hit_ready = 1'b1;
        step();
        checks++;
        if (hit_valid !== 1'b0 || lost_cnt !== 8'(exp_lost)) begin
            errors++; $display("FAIL lost_accept: got v=%b lost=%0d expected v=0 lost=%0d",
                               hit_valid, lost_cnt, exp_lost);
        end
    endtask

    task automatic test_reset_midcount();
        logic [7:0] le_ts;
        en = 1'b1; hit_ready = 1'b1;
        cfg_wr = 1'b1; cfg_data = 10'h3FF;
        step();
        cfg_wr = 1'b0;
        ts = 8'h77;
        outdis = 1'b0;
        step(); step(); step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({S1, S0, DTH2, DTH1} !== 10'd0) begin
            errors++; $display("FAIL midreset_cfg: got %h expected 000", {S1, S0, DTH2, DTH1});
        end
        checks++;
        if ({hit_valid, hit_ts, hit_tot, lost_cnt} !== 21'd0) begin
            errors++; $display("FAIL midreset_hit: got v=%b ts=%h tot=%h lost=%h expected all 0",
                               hit_valid, hit_ts, hit_tot, lost_cnt);
        end
        outdis = 1'b1;
        step(); step();
        rst_n = 1'b1;
        exp_lost = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (hit_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_no_hit: cycle %0d got %b expected 0", i, hit_valid);
            end
        end
        launch(7, le_ts);
        step(); step(); step();
        checks++;
        if (hit_valid !== 1'b1 || hit_ts !== le_ts || hit_tot !== 4'd7 || lost_cnt !== 8'd0) begin
            errors++; $display("FAIL midreset_fresh_hit: got v=%b ts=%h tot=%0d lost=%0d expected v=1 ts=%h tot=7 lost=0",
                               hit_valid, hit_ts, hit_tot, lost_cnt, le_ts);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_config();
        test_basic_hit();
        test_random_pulses();
        test_enable_drop();
        test_stall_and_lost();
        test_reset_midcount();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
